// File: rtl/alu_pkg.sv
// Shared encodings for the iterative ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    AcAdd  = 3'b000,
    AcAdc  = 3'b001,
    AcSub  = 3'b010,
    AcSbc  = 3'b011,
    AcAnd  = 3'b100,
    AcOr   = 3'b101,
    AcXor  = 3'b110,
    AcNand = 3'b111
  } acode_e;

  typedef enum logic [1:0] {
    ScShl = 2'b00,
    ScSar = 2'b01,
    ScRol = 2'b10,
    ScRor = 2'b11
  } scode_e;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

endpackage

// File: rtl/alu_addsub.sv
// Combinational add/subtract with carry-in; cout reports borrow when subtracting.
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH:0]   full;

  // Subtraction is a + ~b + ~borrow_in; the raw carry out is then the inverse of borrow.
  always_comb begin
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? ~cin : cin;
    full    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
    sum     = full[WIDTH-1:0];
    cout    = sub ? ~full[WIDTH] : full[WIDTH];
    ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle arithmetic/logic ops, bit-serial shifts and rotates,
// with a registered result and Z/C/N/V flag register.
module iter_alu import alu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_shift,
  input  logic [2:0]       acode,
  input  logic [1:0]       scode,
  input  logic             update_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf
);

  localparam logic [SHW-1:0] CntOne = 1;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] r_q;
  logic [SHW-1:0]   cnt_q;
  scode_e           scode_q;
  logic             upd_q;
  logic             z_q, c_q, n_q, v_q;

  logic [WIDTH-1:0] as_sum;
  logic             as_cout, as_ovf;
  logic [WIDTH-1:0] op_r;
  logic [WIDTH-1:0] sh_r;
  logic             sh_c;
  logic [SHW-1:0]   amt;

  assign amt = b[SHW-1:0];

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (a),
    .b    (b),
    .cin  (acode[0] & c_q),
    .sub  (acode[1]),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  always_comb begin
    op_r = as_sum;
    case (acode_e'(acode))
      AcAnd:   op_r = a & b;
      AcOr:    op_r = a | b;
      AcXor:   op_r = a ^ b;
      AcNand:  op_r = ~(a & b);
      default: op_r = as_sum;
    endcase
  end

  // One bit position per cycle; sh_c is the bit leaving the word on this step.
  always_comb begin
    sh_r = r_q;
    sh_c = 1'b0;
    unique case (scode_q)
      ScShl: begin sh_r = {r_q[WIDTH-2:0], 1'b0};        sh_c = r_q[WIDTH-1]; end
      ScSar: begin sh_r = {r_q[WIDTH-1], r_q[WIDTH-1:1]}; sh_c = r_q[0];       end
      ScRol: begin sh_r = {r_q[WIDTH-2:0], r_q[WIDTH-1]}; sh_c = r_q[WIDTH-1]; end
      ScRor: begin sh_r = {r_q[0], r_q[WIDTH-1:1]};       sh_c = r_q[0];       end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      cnt_q   <= '0;
      scode_q <= ScShl;
      upd_q   <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            upd_q   <= update_flags;
            scode_q <= scode_e'(scode);
            if (is_shift) begin
              r_q   <= a;
              cnt_q <= amt;
              if (amt == '0) begin
                state_q <= StDone;
                if (update_flags) begin
                  z_q <= (a == '0);
                  n_q <= a[WIDTH-1];
                end
              end else begin
                state_q <= StShift;
              end
            end else begin
              r_q     <= op_r;
              state_q <= StDone;
              if (update_flags) begin
                z_q <= (op_r == '0);
                n_q <= op_r[WIDTH-1];
                if (!acode[2]) begin
                  c_q <= as_cout;
                  v_q <= as_ovf;
                end
              end
            end
          end
        end
        StShift: begin
          r_q   <= sh_r;
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_q <= StDone;
            if (upd_q) begin
              z_q <= (sh_r == '0);
              n_q <= sh_r[WIDTH-1];
              c_q <= sh_c;
            end
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign r         = r_q;
  assign zero      = z_q;
  assign carry     = c_q;
  assign neg       = n_q;
  assign ovf       = v_q;

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (>=4, power of two).
REQ-002 Parameter: SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B, or shift amount (low SHW bits).
REQ-009 is_shift  in  1  1 = shift/rotate op, 0 = arithmetic/logic op.
REQ-010 acode  in  3  000 add, 001 adc, 010 sub, 011 sbc, 100 and, 101 or, 110 xor, 111 nand.
REQ-011 scode  in  2  00 shl, 01 sar, 10 rol, 11 ror.
REQ-012 update_flags  in  1  op writes the flag register.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 r  out  WIDTH  result, registered.
REQ-016 zero, carry, neg, ovf  out  1 each  registered flag register Z, C, N, V.

Function
REQ-017 Request accepted on a clk edge where in_valid && in_ready; a, b, codes, update_flags latched then; inputs ignored otherwise.
REQ-018 States: IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-019 IDLE -> DONE on accepted non-shift op, or shift op with amount 0; IDLE -> SHIFT on shift op with amount != 0.
REQ-020 Non-shift op: r and flags written at acceptance edge; out_valid high the next cycle (latency 1).
REQ-021 SHIFT: one bit position per cycle, down-counter loaded with b[SHW-1:0]; -> DONE on the edge where the counter reaches 0; latency amount+1 cycles from acceptance to out_valid.
REQ-022 Shift amount = b mod WIDTH; amount 0 gives r = a, C unchanged.
REQ-023 DONE: out_valid = 1, r and flags stable until out_valid && out_ready; then -> IDLE (no same-cycle new accept).
REQ-024 add: r = a+b; adc: r = a+b+C; C = carry out of bit WIDTH-1.
REQ-025 sub: r = a-b; sbc: r = a-b-C; C = 1 iff unsigned borrow occurred.
REQ-026 V = signed two's-complement overflow for add/adc/sub/sbc; unchanged for logic and shift ops.
REQ-027 Logic ops: C unchanged.
REQ-028 shl: zero fill, C = last bit shifted out of MSB; sar: MSB fill, C = last bit shifted out of LSB; rol/ror: circular, C = last bit rotated through the MSB (rol) / LSB (ror).
REQ-029 Z = (r == 0), N = r[WIDTH-1], for every op.
REQ-030 Flags written only when latched update_flags = 1; else all four flags retain value; r always written.
REQ-031 C used by adc/sbc is the flag value at acceptance.

Reset
REQ-032 rst high at an edge: state IDLE, r = 0, Z = C = N = V = 0, out_valid = 0, counter = 0; rst dominates in_valid.
REQ-033 rst during SHIFT or DONE aborts the op; no result or flag update is produced.
REQ-034 in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-035 Package alu_pkg holds the acode and scode enumerations and the state enumeration.
REQ-036 One sub-module alu_addsub: combinational WIDTH-bit add/subtract with carry-in, producing sum, carry/borrow and overflow.
REQ-037 Shifter is a single-bit shift stage plus the counter inside iter_alu; no barrel shifter.

Verification
REQ-038 WIDTH=8, rst, add a=0x7F b=0x01 update_flags=1 -> r=0x80, N=1 V=1 C=0 Z=0, out_valid 1 cycle after accept.
REQ-039 add 0xFF+0x01 update_flags=1, then adc 0x00+0x00 -> r=0x00 Z=1 C=1; then r=0x01 C=0 Z=0.
REQ-040 sub a=0x05 b=0x07 update_flags=1 -> r=0xFE C=1 N=1; then and 0xF0&0x0F -> r=0x00 Z=1, C still 1.
REQ-041 ror a=0x81 b=3 update_flags=1 -> out_valid 4 cycles after accept, r=0x30, C=0; sar a=0x80 b=9 -> r=0xC0 after 2 cycles (amount 1), C=0.
REQ-042 out_ready=0 for 5 cycles in DONE -> r, flags, out_valid stable, in_ready 0; rst asserted mid-SHIFT (shl b=7) -> next cycle out_valid=0, flags 0, in_ready 1.
